// File: rtl/fpa_operand_issue_if.sv
// Bundle of the operand-issue front end signals: packed input pairs, the unpacked adder
// handshake and the packed result port.
interface fpa_operand_issue_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;

  logic       a_sign;
  logic       b_sign;
  logic [3:0] a_exp;
  logic [3:0] b_exp;
  logic [2:0] a_mant;
  logic [2:0] b_mant;
  logic       fpa_start;

  logic       fpa_done;
  logic       fpa_sign;
  logic [3:0] fpa_exp;
  logic [2:0] fpa_mant;
  logic [3:0] fpa_except;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_flags;

  // Issue block side.
  modport master (
    input  in_valid, in_a, in_b,
    output in_ready,
    output a_sign, b_sign, a_exp, b_exp, a_mant, b_mant, fpa_start,
    input  fpa_done, fpa_sign, fpa_exp, fpa_mant, fpa_except,
    output res_valid, res_data, res_flags,
    input  res_ready
  );

  // Producer / adder / consumer side.
  modport slave (
    output in_valid, in_a, in_b,
    input  in_ready,
    input  a_sign, b_sign, a_exp, b_exp, a_mant, b_mant, fpa_start,
    output fpa_done, fpa_sign, fpa_exp, fpa_mant, fpa_except,
    input  res_valid, res_data, res_flags,
    output res_ready
  );
endinterface

// File: rtl/fpa_operand_issue.sv
// 8-bit FP adder front end: operand FIFO, special-case classification and bypass, adder
// issue with a done timeout, and a held valid/ready result port.
module fpa_operand_issue #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                clr,
  fpa_operand_issue_if.master bus
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW        = $clog2(TIMEOUT);
  localparam logic [AW:0]   FullCnt   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CntOne    = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TimerOne  = TW'(1);
  localparam logic [7:0]    QNan      = 8'h7C;

  typedef enum logic [2:0] {StIdle, StClassify, StIssue, StWait, StOut} state_e;

  // ---------------------------------------------------------------- operand FIFO
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ne_q;
  logic          in_ready, push, pop;
  state_e        state_q;

  assign in_ready = (count_q != FullCnt);
  assign push     = bus.in_valid & in_ready;
  // ne_q lags occupancy by a cycle, so a fresh entry is seen by IDLE one cycle after its write.
  assign pop      = (state_q == StIdle) & ne_q & (count_q != '0);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ne_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      case ({push, pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
      ne_q <= (count_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
  end

  // ---------------------------------------------------------------- classification
  logic [7:0] op_a_q, op_b_q;
  logic       a_zero, a_den, a_inf, a_nan;
  logic       b_zero, b_den, b_inf, b_nan;
  logic [7:0] a_flat, b_flat;
  logic       bypass, byp_invalid, flushed;
  logic [7:0] byp_data;

  // a_zero/b_zero also cover denormals, which are flushed to signed zero.
  assign a_zero  = (op_a_q[6:3] == 4'h0);
  assign a_den   = a_zero & (op_a_q[2:0] != 3'h0);
  assign a_inf   = (op_a_q[6:3] == 4'hF) & (op_a_q[2:0] == 3'h0);
  assign a_nan   = (op_a_q[6:3] == 4'hF) & (op_a_q[2:0] != 3'h0);
  assign b_zero  = (op_b_q[6:3] == 4'h0);
  assign b_den   = b_zero & (op_b_q[2:0] != 3'h0);
  assign b_inf   = (op_b_q[6:3] == 4'hF) & (op_b_q[2:0] == 3'h0);
  assign b_nan   = (op_b_q[6:3] == 4'hF) & (op_b_q[2:0] != 3'h0);
  assign a_flat  = a_den ? {op_a_q[7], 7'h00} : op_a_q;
  assign b_flat  = b_den ? {op_b_q[7], 7'h00} : op_b_q;
  assign flushed = a_den | b_den;
  assign bypass  = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

  always_comb begin
    byp_data    = a_flat;
    byp_invalid = 1'b0;
    if (a_nan | b_nan) begin
      byp_data    = QNan;
      byp_invalid = 1'b1;
    end else if (a_inf & b_inf & (op_a_q[7] ^ op_b_q[7])) begin
      byp_data    = QNan;
      byp_invalid = 1'b1;
    end else if (a_inf) begin
      byp_data = a_flat;
    end else if (b_inf) begin
      byp_data = b_flat;
    end else if (a_zero & b_zero) begin
      byp_data = {op_a_q[7] & op_b_q[7], 7'h00};
    end else if (a_zero) begin
      byp_data = b_flat;
    end else begin
      byp_data = a_flat;
    end
  end

  // ---------------------------------------------------------------- control FSM
  logic [7:0]    iss_a_q, iss_b_q;
  logic          start_q;
  logic [TW-1:0] timer_q;
  logic          res_valid_q;
  logic [7:0]    res_data_q;
  logic [3:0]    res_flags_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= StIdle;
      op_a_q      <= '0;
      op_b_q      <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      start_q     <= 1'b0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            op_a_q  <= mem_q[rd_ptr_q][15:8];
            op_b_q  <= mem_q[rd_ptr_q][7:0];
            state_q <= StClassify;
          end
        end
        StClassify: begin
          if (bypass) begin
            res_data_q  <= byp_data;
            res_flags_q <= {byp_invalid, 1'b0, flushed, 1'b0};
            res_valid_q <= 1'b1;
            state_q     <= StOut;
          end else begin
            iss_a_q <= op_a_q;
            iss_b_q <= op_b_q;
            start_q <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          start_q <= 1'b0;
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // done is tested first so it wins over a simultaneous timeout.
          if (bus.fpa_done) begin
            res_data_q  <= {bus.fpa_sign, bus.fpa_exp, bus.fpa_mant};
            res_flags_q <= {1'b0, |bus.fpa_except, 2'b00};
            res_valid_q <= 1'b1;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            state_q     <= StOut;
          end else if (timer_q == TimerLast) begin
            res_data_q  <= QNan;
            res_flags_q <= 4'b1001;
            res_valid_q <= 1'b1;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            state_q     <= StOut;
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end
        StOut: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.a_sign    = iss_a_q[7];
  assign bus.a_exp     = iss_a_q[6:3];
  assign bus.a_mant    = iss_a_q[2:0];
  assign bus.b_sign    = iss_b_q[7];
  assign bus.b_exp     = iss_b_q[6:3];
  assign bus.b_mant    = iss_b_q[2:0];
  assign bus.fpa_start = start_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_flags = res_flags_q;

endmodule

// File: tb/tb_fpa_operand_issue.sv
// Self-checking bench for fpa_operand_issue: directed cases plus a randomized stream scored
// against a behavioural model of the bypass rules and a stand-in adder.
module tb_fpa_operand_issue;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fpa_operand_issue_if bus ();

  fpa_operand_issue #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Stand-in adder: its "sum" is an arbitrary but fixed function of the operands.
  function automatic logic [11:0] stub_add(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    s = a + b - 8'h30;
    return {a[3:0] ^ b[3:0], s};
  endfunction

  logic stub_enable = 1'b0;
  int   stub_delay  = 1;
  int   manual_req  = 0;
  int   starts      = 0;
  int   hold_bad    = 0;

  initial begin
    int         pend;
    int         manual_ack;
    bit         auto_done;
    logic [7:0] cap_a, cap_b, cur_a, cur_b;
    logic [11:0] r;
    pend = -1;
    manual_ack = 0;
    auto_done = 1'b0;
    cap_a = '0;
    cap_b = '0;
    bus.fpa_done = 1'b0;
    bus.fpa_sign = 1'b0;
    bus.fpa_exp = '0;
    bus.fpa_mant = '0;
    bus.fpa_except = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.fpa_done = 1'b0;
      if (!clr) pend = -1;
      cur_a = {bus.a_sign, bus.a_exp, bus.a_mant};
      cur_b = {bus.b_sign, bus.b_exp, bus.b_mant};
      if (manual_req != manual_ack) begin
        manual_ack = manual_req;
        pend = 0;
        auto_done = 1'b0;
      end
      if (pend == 0) begin
        if (auto_done && (cur_a != cap_a || cur_b != cap_b)) hold_bad++;
        r = stub_add(cur_a, cur_b);
        {bus.fpa_sign, bus.fpa_exp, bus.fpa_mant} = r[7:0];
        bus.fpa_except = r[11:8];
        bus.fpa_done = 1'b1;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (bus.fpa_start) begin
        starts++;
        cap_a = cur_a;
        cap_b = cur_b;
        if (stub_enable) begin
          pend = stub_delay;
          auto_done = 1'b1;
        end
      end
    end
  end

  // Reference model: {normal_pair, flags, data}. Normal pairs take the stand-in adder's answer.
  function automatic logic [12:0] predict(input logic [7:0] a, input logic [7:0] b);
    int          ea, eb, ma, mb;
    logic [7:0]  x, y;
    logic [3:0]  f;
    logic [11:0] r;
    ea = (int'(a) / 8) % 16;
    eb = (int'(b) / 8) % 16;
    ma = int'(a) % 8;
    mb = int'(b) % 8;
    x = a;
    y = b;
    f = 4'b0000;
    if (ea == 0 && ma != 0) begin x = a & 8'h80; f = 4'b0010; end
    if (eb == 0 && mb != 0) begin y = b & 8'h80; f = 4'b0010; end
    if ((ea == 15 && ma != 0) || (eb == 15 && mb != 0)) return {1'b0, f | 4'b1000, 8'h7C};
    if (ea == 15 && eb == 15 && a[7] != b[7]) return {1'b0, f | 4'b1000, 8'h7C};
    if (ea == 15) return {1'b0, f, x};
    if (eb == 15) return {1'b0, f, y};
    if (ea == 0 && eb == 0) return {1'b0, f, (a[7] && b[7]) ? 8'h80 : 8'h00};
    if (ea == 0) return {1'b0, f, y};
    if (eb == 0) return {1'b0, f, x};
    r = stub_add(a, b);
    return {1'b1, 1'b0, |r[11:8], 2'b00, r[7:0]};
  endfunction

  function automatic logic [7:0] rand_op();
    logic       s;
    logic [3:0] e;
    logic [2:0] m;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0:       begin e = 4'h0; m = 3'h0; end
      1:       begin e = 4'h0; m = 3'($urandom_range(1, 7)); end
      2:       begin e = 4'hF; m = 3'h0; end
      3:       begin e = 4'hF; m = 3'($urandom_range(1, 7)); end
      default: begin e = 4'($urandom_range(1, 14)); m = 3'($urandom_range(0, 7)); end
    endcase
    return {s, e, m};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res(input string tag, input int max);
    int n;
    n = 0;
    while (!bus.res_valid && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.res_valid), 32'd1);
  endtask

  task automatic wait_start(input string tag, input int max);
    int n;
    n = 0;
    while (!bus.fpa_start && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.fpa_start), 32'd1);
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic push1(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Idle block, empty FIFO: accepted at edge 0, result valid only after edge 3.
  task automatic bypass_case(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [11:0] exp);
    int s;
    s = starts;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_e0"}, 32'(bus.res_valid), 32'd0);
    tick();
    tick();
    check({tag, "_e2"}, 32'(bus.res_valid), 32'd0);
    tick();
    check({tag, "_e3"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_res"}, 32'({bus.res_flags, bus.res_data}), 32'(exp));
    check({tag, "_nostart"}, 32'(starts - s), 32'd0);
    accept();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int          s;
    bit          seen;
    logic [7:0]  d0;
    logic [11:0] exp6 [3];
    logic [11:0] expq [$];
    int          normals;

    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.res_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_outputs", 32'({bus.a_sign, bus.a_exp, bus.a_mant, bus.b_sign, bus.b_exp,
                              bus.b_mant, bus.fpa_start, bus.res_valid, bus.res_data,
                              bus.res_flags}), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    clr = 1'b1;
    tick();

    // T2: normal pair through the adder
    stub_enable = 1'b1;
    stub_delay = 2;
    s = starts;
    push1(8'h38, 8'h38);
    wait_res("t2_valid", 30);
    check("t2_starts", 32'(starts - s), 32'd1);
    check("t2_data", 32'(bus.res_data), 32'h40);
    check("t2_flags", 32'(bus.res_flags), 32'h0);
    accept();
    check("t2_release", 32'(bus.res_valid), 32'd0);

    // T3 / T4: bypass cases
    bypass_case("t3_nan", 8'h7C, 8'h38, {4'b1000, 8'h7C});
    bypass_case("t4_infinf", 8'h78, 8'hF8, {4'b1000, 8'h7C});
    bypass_case("t4_denorm", 8'h01, 8'h38, {4'b0010, 8'h38});
    bypass_case("t4_negzero", 8'h80, 8'h83, {4'b0010, 8'h80});

    // T5: timeout after TIMEOUT cycles in WAIT
    stub_enable = 1'b0;
    push1(8'h38, 8'h38);
    wait_start("t5_start", 20);
    repeat (TIMEOUT) tick();
    check("t5_not_yet", 32'(bus.res_valid), 32'd0);
    tick();
    check("t5_valid", 32'(bus.res_valid), 32'd1);
    check("t5_res", 32'({bus.res_flags, bus.res_data}), 32'h97C);
    accept();

    // T5b: done arriving on the expiry cycle wins
    push1(8'h38, 8'h38);
    wait_start("t5b_start", 20);
    repeat (TIMEOUT - 1) tick();
    #1;
    manual_req++;
    tick();
    check("t5b_not_yet", 32'(bus.res_valid), 32'd0);
    tick();
    check("t5b_valid", 32'(bus.res_valid), 32'd1);
    check("t5b_res", 32'({bus.res_flags, bus.res_data}), 32'h040);
    accept();

    // T6: backpressure, results emerge in push order
    stub_enable = 1'b1;
    stub_delay = 1;
    exp6[0] = 12'h040;
    exp6[1] = 12'h87C;
    exp6[2] = 12'h278;
    push1(8'h38, 8'h38);
    push1(8'h7C, 8'h38);
    push1(8'h78, 8'h01);
    check("t6_full", 32'(bus.in_ready), 32'd0);
    wait_res("t6_first", 30);
    d0 = bus.res_data;
    repeat (6) tick();
    check("t6_held_valid", 32'(bus.res_valid), 32'd1);
    check("t6_held_data", 32'(bus.res_data), 32'(d0));
    check("t6_still_full", 32'(bus.in_ready), 32'd0);
    bus.res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      while (!bus.res_valid && n < 40) begin
        tick();
        n++;
      end
      check("t6_order", 32'({bus.res_flags, bus.res_data}), 32'(exp6[k]));
      tick();
    end
    bus.res_ready = 1'b0;

    // T1: reset mid-WAIT drops the pair; a later done is ignored
    stub_enable = 1'b0;
    push1(8'h38, 8'h38);
    wait_start("t1_start", 20);
    tick();
    tick();
    clr = 1'b0;
    #1;
    check("t1_outputs", 32'({bus.a_sign, bus.a_exp, bus.a_mant, bus.b_sign, bus.b_exp,
                             bus.b_mant, bus.fpa_start, bus.res_valid, bus.res_data,
                             bus.res_flags}), 32'd0);
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    tick();
    clr = 1'b1;
    #1;
    manual_req++;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (bus.res_valid || bus.fpa_start) seen = 1'b1;
    end
    check("t1_no_result", 32'(seen), 32'd0);

    // Randomized stream against the reference model
    stub_enable = 1'b1;
    normals = 0;
    s = starts;
    for (int c = 0; c < 900; c++) begin
      logic [7:0]  ra, rb;
      logic        pv, pr;
      logic [11:0] got;
      logic [12:0] p;
      ra = rand_op();
      rb = rand_op();
      bus.in_valid = (c < 400) && ($urandom_range(0, 2) != 0);
      bus.in_a = ra;
      bus.in_b = rb;
      bus.res_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
      stub_delay = int'($urandom_range(0, 4));
      pv = bus.in_valid & bus.in_ready;
      pr = bus.res_valid & bus.res_ready;
      got = {bus.res_flags, bus.res_data};
      tick();
      if (pv) begin
        p = predict(ra, rb);
        expq.push_back(p[11:0]);
        if (p[12]) normals++;
      end
      if (pr) begin
        if (expq.size() == 0) check("rand_unexpected", 32'(expq.size()), 32'd1);
        else check("rand_res", 32'(got), 32'(expq.pop_front()));
      end
    end
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    check("rand_drained", 32'(expq.size()), 32'd0);
    check("rand_starts", 32'(starts - s), 32'(normals));
    check("operand_hold", 32'(hold_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
